// File: rtl/alu_multicycle.sv
// ============================================================================
// alu_multicycle : registered ALU with valid/ready handshake and an iterative
//                  shift-add multiplier (one partial product per cycle)
// Revision 1.0
// ============================================================================
`default_nettype none

module alu_multicycle #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] ALUop1,
  input  logic [DATA_WIDTH-1:0] ALUop2,
  input  logic [CTRL_WIDTH-1:0] ALUctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  eq,
  output logic                  zero,
  output logic                  busy
);

  localparam int SHW   = $clog2(DATA_WIDTH);
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CTRL_WIDTH-1:0] OP_ADD = CTRL_WIDTH'(0);
  localparam logic [CTRL_WIDTH-1:0] OP_SUB = CTRL_WIDTH'(1);
  localparam logic [CTRL_WIDTH-1:0] OP_AND = CTRL_WIDTH'(2);
  localparam logic [CTRL_WIDTH-1:0] OP_OR  = CTRL_WIDTH'(3);
  localparam logic [CTRL_WIDTH-1:0] OP_XOR = CTRL_WIDTH'(4);
  localparam logic [CTRL_WIDTH-1:0] OP_SLT = CTRL_WIDTH'(5);
  localparam logic [CTRL_WIDTH-1:0] OP_SLL = CTRL_WIDTH'(6);
  localparam logic [CTRL_WIDTH-1:0] OP_MUL = CTRL_WIDTH'(7);

  logic [1:0]            state_q,  state_d;
  logic [DATA_WIDTH-1:0] sum_q,    sum_d;
  logic                  eq_q,     eq_d;
  logic [DATA_WIDTH-1:0] acc_q,    acc_d;
  logic [DATA_WIDTH-1:0] mcand_q,  mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic [DATA_WIDTH-1:0] alu_res;

  // Single-cycle ops; unknown codes fall through to add.
  always_comb begin
    alu_res = ALUop1 + ALUop2;
    case (ALUctrl)
      OP_ADD: alu_res = ALUop1 + ALUop2;
      OP_SUB: alu_res = ALUop1 - ALUop2;
      OP_AND: alu_res = ALUop1 & ALUop2;
      OP_OR:  alu_res = ALUop1 | ALUop2;
      OP_XOR: alu_res = ALUop1 ^ ALUop2;
      OP_SLT: alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(ALUop1) < $signed(ALUop2))};
      OP_SLL: alu_res = ALUop1 << ALUop2[SHW-1:0];
      default: alu_res = ALUop1 + ALUop2;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    eq_d     = eq_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          eq_d = (ALUop1 == ALUop2);
          if (ALUctrl == OP_MUL) begin
            acc_d    = '0;
            mcand_d  = ALUop1;
            mplier_d = ALUop2;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            sum_d   = alu_res;
            state_d = S_DONE;
          end
        end
      end
      S_MUL: begin
        // Always runs the full DATA_WIDTH iterations so latency is fixed.
        acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == C_LAST) begin
          sum_d   = acc_d;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sum_q    <= '0;
      eq_q     <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      eq_q     <= eq_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_MUL);
  assign sum       = sum_q;
  assign eq        = eq_q;
  assign zero      = (sum_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_alu_multicycle.sv
// ============================================================================
// tb_alu_multicycle : vector table + scoreboard bench for alu_multicycle
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_alu_multicycle;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a_in;
  logic [DW-1:0] b_in;
  logic [2:0]    ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] sum;
  logic          eq;
  logic          zero;
  logic          busy;

  int checks = 0;
  int errors = 0;

  alu_multicycle #(.DATA_WIDTH(DW), .CTRL_WIDTH(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUop1    (a_in),
    .ALUop2    (b_in),
    .ALUctrl   (ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .eq        (eq),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp_sum;
    logic          exp_eq;
  } vec_t;

  typedef struct {
    logic [DW-1:0] sum;
    logic          eq;
    int            lat;
    int            busy_cycles;
  } exp_t;

  vec_t vecs[16];
  exp_t sb[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one op, push its expectation, then wait for and consume the result.
  task automatic run_op(input string name, input logic [2:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] exp_sum, input logic exp_eq);
    exp_t e;
    int   lat;
    int   bcnt;
    int   guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (!in_ready) begin
      chk({name, "_ready_timeout"}, 32'(in_ready), 32'd1);
      return;
    end
    e.sum         = exp_sum;
    e.eq          = exp_eq;
    e.lat         = (op == 3'd7) ? DW + 1 : 1;
    e.busy_cycles = (op == 3'd7) ? DW : 0;
    sb.push_back(e);
    in_valid = 1'b1;
    ctrl     = op;
    a_in     = a;
    b_in     = b;
    tick();
    in_valid = 1'b0;
    a_in     = '0;
    b_in     = '0;
    lat  = 1;
    bcnt = busy ? 1 : 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
      if (busy) bcnt++;
    end
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({name, "_latency"}, 32'(lat), 32'(e.lat));
    chk({name, "_busy_cycles"}, 32'(bcnt), 32'(e.busy_cycles));
    chk({name, "_sum"}, sum, e.sum);
    chk({name, "_eq"}, 32'(eq), 32'(e.eq));
    chk({name, "_zero"}, 32'(zero), 32'(e.sum == '0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, "_idle_after"}, {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  initial begin
    vecs[0]  = '{3'd0, 32'd5,          32'd7,          32'd12,         1'b0};
    vecs[1]  = '{3'd1, 32'd9,          32'd9,          32'd0,          1'b1};
    vecs[2]  = '{3'd5, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0};
    vecs[3]  = '{3'd5, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[4]  = '{3'd7, 32'hFFFF_FFFF,  32'd3,          32'hFFFF_FFFD,  1'b0};
    vecs[5]  = '{3'd6, 32'd1,          32'd35,         32'd8,          1'b0};
    vecs[6]  = '{3'd0, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
    vecs[7]  = '{3'd2, 32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200,  1'b0};
    vecs[8]  = '{3'd3, 32'hA0A0_0000,  32'h0505_0001,  32'hA5A5_0001,  1'b0};
    vecs[9]  = '{3'd4, 32'hFFFF_0000,  32'h0F0F_0F0F,  32'hF0F0_0F0F,  1'b0};
    vecs[10] = '{3'd1, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0};
    vecs[11] = '{3'd7, 32'h0000_1234,  32'd0,          32'd0,          1'b0};
    vecs[12] = '{3'd7, 32'h0001_0000,  32'h0001_0000,  32'd0,          1'b1};
    vecs[13] = '{3'd7, 32'd7,          32'd6,          32'd42,         1'b0};
    vecs[14] = '{3'd5, 32'h8000_0000,  32'h7FFF_FFFF,  32'd1,          1'b0};
    vecs[15] = '{3'd6, 32'h8000_0001,  32'd1,          32'd2,          1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    ctrl      = '0;
    tick();
    tick();
    chk("reset_flags", {27'd0, in_ready, out_valid, busy, eq, zero}, 32'b10001);
    chk("reset_sum", sum, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_sum, vecs[i].exp_eq);
    end

    // Result held in DONE while the consumer stalls; new requests are ignored.
    in_valid = 1'b1; ctrl = 3'd0; a_in = 32'd5; b_in = 32'd7;
    tick();
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      ctrl = 3'd1; a_in = 32'd100; b_in = 32'd1;
      tick();
      chk($sformatf("hold_sum_%0d", k), sum, 32'd12);
      chk($sformatf("hold_flags_%0d", k), {29'd0, out_valid, in_ready, eq}, 32'b100);
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bubble_idle", {30'd0, in_ready, out_valid}, 32'b10);
    in_valid = 1'b0;
    tick();
    chk("bubble_no_accept", {30'd0, in_ready, out_valid}, 32'b10);
    chk("bubble_sum_kept", sum, 32'd12);

    // Abort a multiply partway through with reset.
    in_valid = 1'b1; ctrl = 3'd7; a_in = 32'd5; b_in = 32'd5;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    chk("midmul_busy", {30'd0, busy, out_valid}, 32'b10);
    chk("midmul_eq", 32'(eq), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_flags", {27'd0, in_ready, out_valid, busy, eq, zero}, 32'b10001);
    chk("abort_sum", sum, 32'd0);
    tick();
    chk("abort_stays_idle", {29'd0, in_ready, out_valid, busy}, 32'b100);

    run_op("post_abort_add", 3'd0, 32'd20, 32'd22, 32'd42, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
